uart_frame_tx: RTL and testbench

//  Serial transmit stage fed by the CRC block. Latches a FRAME_BITS-wide word
//  (payload plus CRC byte) when its enable pulse arrives. Sends the word as
//  NUM_BYTES consecutive UART 8N1 characters on a single tx line.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_frame_tx.sv | 143 ++++++++++++++
 tb/tb_uart_frame_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame transmitter: FSM state encoding,
// default baud divisor and an index-width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // 50 MHz system clock / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // Width of a counter/index covering 0..n-1, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each line bit. A clear holds the count at zero (used while idle).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_bit_end
);

    localparam int CW = idx_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    assign o_bit_end = (r_cnt == LAST_CNT);

    // Free-running bit counter, wrapping at every bit boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Sends a latched FRAME_BITS-wide word as NUM_BYTES back-to-back UART 8N1
// characters, most significant byte first. All outputs are registered.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int FRAME_BITS   = 56,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame_in,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int NUM_BYTES = FRAME_BITS / 8;
    localparam int BW = idx_width(NUM_BYTES);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);

    uart_state_e           r_state;
    uart_state_e           w_nxt_state;
    logic [FRAME_BITS-1:0] r_frame_q;
    logic [BW-1:0]         r_byte_idx;
    logic [BW-1:0]         w_nxt_byte_idx;
    logic [2:0]            r_bit_idx;
    logic [2:0]            w_nxt_bit_idx;
    logic [7:0]            w_cur_byte;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_nxt_tx;
    logic                  w_nxt_done;
    logic                  w_accept;
    logic                  w_baud_clr;
    logic                  w_bit_end;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_baud_clr),
        .o_bit_end(w_bit_end)
    );

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_baud_clr = (r_state == ST_IDLE);

    // Byte mux over the held frame; frame_q itself is never shifted
    always_comb begin
        w_cur_byte = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            w_cur_byte = w_cur_byte |
                (r_frame_q[FRAME_BITS-1-8*i -: 8] & {8{r_byte_idx == BW'(i)}});
        end
    end

    // Next-state, index and line-level logic
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_byte_idx = r_byte_idx;
        w_nxt_bit_idx  = r_bit_idx;
        w_nxt_done     = 1'b0;
        w_nxt_tx       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nxt_state    = ST_START;
                    w_nxt_byte_idx = '0;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_nxt_state   = ST_DATA;
                    w_nxt_bit_idx = 3'd0;
                end else begin
                    w_nxt_state = ST_START;
                end
            end
            ST_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    w_nxt_state = ST_STOP;
                end else if (w_bit_end) begin
                    w_nxt_bit_idx = r_bit_idx + 3'd1;
                end else begin
                    w_nxt_state = ST_DATA;
                end
            end
            ST_STOP: begin
                if (w_bit_end && (r_byte_idx == LAST_BYTE)) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_done  = 1'b1;
                end else if (w_bit_end) begin
                    w_nxt_state    = ST_START;
                    w_nxt_byte_idx = r_byte_idx + BW'(1);
                end else begin
                    w_nxt_state = ST_STOP;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
        // Line level follows the state being entered so tx is registered
        case (w_nxt_state)
            ST_START: w_nxt_tx = 1'b0;
            ST_DATA:  w_nxt_tx = w_cur_byte[w_nxt_bit_idx];
            default:  w_nxt_tx = 1'b1;
        endcase
    end

    // State, indices, frame hold and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_byte_idx <= '0;
            r_bit_idx  <= 3'd0;
            r_frame_q  <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_byte_idx <= w_nxt_byte_idx;
            r_bit_idx  <= w_nxt_bit_idx;
            r_tx       <= w_nxt_tx;
            r_busy     <= (w_nxt_state != ST_IDLE);
            r_done     <= w_nxt_done;
            if (w_accept) begin
                r_frame_q <= frame_in;
            end
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: a mid-bit UART monitor pops expected
// bytes from a scoreboard queue filled whenever a frame is launched.
module tb_uart_frame_tx;

    localparam int CPB       = 4;
    localparam int FB        = 56;
    localparam int NB        = FB / 8;
    localparam int FRAME_CYC = NB * 10 * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [FB-1:0] frame_in;
    logic          tx;
    logic          busy;
    logic          done;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    int         rst_epoch = 0;

    always #5 clk = ~clk;

    uart_frame_tx #(
        .FRAME_BITS  (FB),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .frame_in(frame_in),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Marks every clock edge on which reset was applied, so the monitor can drop a cut-off character
    always @(posedge clk) begin
        if (rst === 1'b1) rst_epoch <= rst_epoch + 1;
    end

    // UART receiver sampling each bit in its middle
    initial begin : monitor
        logic       prev;
        logic [7:0] d;
        logic       sbit;
        logic       pbit;
        int         ep;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && tx === 1'b0) begin
                ep = rst_epoch;
                repeat (CPB / 2) @(negedge clk);
                sbit = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                pbit = tx;
                if (ep == rst_epoch) begin
                    check("start_bit", 64'(sbit), 64'd0);
                    check("stop_bit", 64'(pbit), 64'd1);
                    check("char_expected", 64'(sb.size() > 0), 64'd1);
                    if (sb.size() > 0) check("rx_byte", 64'(d), 64'(sb.pop_front()));
                end
            end
            prev = tx;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    task automatic send(input logic [FB-1:0] f);
        frame_in = f;
        start    = 1'b1;
        for (int i = 0; i < NB; i++) sb.push_back(f[FB-1-8*i -: 8]);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count cycles from the first low tx sample until done; optionally poke a start mid-frame
    task automatic wait_done(input bit poke, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 4 * FRAME_CYC) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 100) begin
                frame_in = {FB{1'b1}};
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    typedef struct {
        logic [FB-1:0] frame;
        bit            alter;
        logic [FB-1:0] alt;
        bit            poke;
        int            exp_len;
    } vec_t;

    vec_t vecs[4];
    int   cyc;
    bit   low_seen;

    initial begin
        vecs[0] = '{frame: 56'h123456789ABC5E, alter: 1'b0, alt: 56'h0, poke: 1'b0, exp_len: FRAME_CYC};
        vecs[1] = '{frame: 56'h123456789ABC5E, alter: 1'b0, alt: 56'h0, poke: 1'b1, exp_len: FRAME_CYC};
        vecs[2] = '{frame: 56'hA5A50F0FC3C381, alter: 1'b1, alt: 56'h5A5AF0F03C3C7E, poke: 1'b0, exp_len: FRAME_CYC};
        vecs[3] = '{frame: 56'h00000000000000, alter: 1'b0, alt: 56'h0, poke: 1'b0, exp_len: FRAME_CYC};

        rst      = 1'b1;
        start    = 1'b0;
        frame_in = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        low_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
        end
        check("idle_after_rst", 64'(low_seen), 64'd0);

        foreach (vecs[v]) begin
            send(vecs[v].frame);
            if (vecs[v].alter) frame_in = vecs[v].alt;
            check("tx_fall", 64'(tx), 64'd0);
            check("busy_on", 64'(busy), 64'd1);
            wait_done(vecs[v].poke, cyc);
            check("frame_len", 64'(cyc), 64'(vecs[v].exp_len));
            check("busy_at_done", 64'(busy), 64'd0);
            check("sb_drained", 64'(sb.size()), 64'd0);
            @(negedge clk);
            check("done_pulse", 64'(done), 64'd0);
            repeat (5) @(negedge clk);
        end

        // Back-to-back: second start lands in the done cycle
        send(56'hDEADBEEF000042);
        wait_done(1'b0, cyc);
        check("b2b_len1", 64'(cyc), 64'(FRAME_CYC));
        check("b2b_drained1", 64'(sb.size()), 64'd0);
        send(56'h00000000000001);
        check("b2b_tx_fall", 64'(tx), 64'd0);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done(1'b0, cyc);
        check("b2b_len2", 64'(cyc), 64'(FRAME_CYC));
        check("b2b_drained2", 64'(sb.size()), 64'd0);
        repeat (5) @(negedge clk);

        // Abort in the data bits of byte 3, then a clean frame
        send(56'h0F1E2D3C4B5A69);
        repeat (130) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        rst   = 1'b1;
        start = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_tx", 64'(tx), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        low_seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
        end
        check("abort_quiet", 64'(low_seen), 64'd0);
        send(56'hC0FFEE12345678);
        check("post_abort_tx_fall", 64'(tx), 64'd0);
        wait_done(1'b0, cyc);
        check("post_abort_len", 64'(cyc), 64'(FRAME_CYC));
        check("post_abort_drained", 64'(sb.size()), 64'd0);

        repeat (60) @(negedge clk);
        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
